// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial slot stream in, parallel frame word and framing status out.
interface tdm_demux_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1
);
    localparam int SELW = $clog2(CHANNELS);

    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic                      sync;
    logic                      err_clr;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic [SELW-1:0]           sel;
    logic                      locked;
    logic                      err;

    modport master (
        output in_data, in_valid, sync, err_clr,
        input  out_data, out_valid, sel, locked, err
    );

    modport slave (
        input  in_data, in_valid, sync, err_clr,
        output out_data, out_valid, sel, locked, err
    );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: realigns a SYNC-marked serial slot stream into parallel frames, flagging framing faults.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1
) (
    input logic         clk_i,
    input logic         rst_i,
    tdm_demux_if.slave  bus
);
    localparam int SELW = $clog2(CHANNELS);
    localparam int SW   = (CHANNELS - 1) * WIDTH;
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                    state_q, state_d;
    logic [SELW-1:0]           sel_q, sel_d;
    logic [SW-1:0]             shadow_q, shadow_d;
    logic [CHANNELS*WIDTH-1:0] out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      err_q, err_d;
    logic                      fault;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        fault       = 1'b0;
        if (bus.in_valid) begin
            if (state_q == HUNT) begin
                if (bus.sync) begin
                    shadow_d[WIDTH-1:0] = bus.in_data;
                    sel_d               = SELW'(1);
                    state_d             = LOCK;
                end
            end else if (bus.sync) begin
                // a marker anywhere but slot 0 restarts the frame on this slot
                fault               = (sel_q != '0);
                shadow_d[WIDTH-1:0] = bus.in_data;
                sel_d               = SELW'(1);
            end else if (sel_q == '0) begin
                fault   = 1'b1;
                state_d = HUNT;
            end else if (sel_q == LAST) begin
                out_d       = {bus.in_data, shadow_q};
                out_valid_d = 1'b1;
                sel_d       = '0;
            end else begin
                shadow_d[sel_q*WIDTH +: WIDTH] = bus.in_data;
                sel_d                          = sel_q + 1'b1;
            end
        end
        err_d = fault | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= HUNT;
            sel_q       <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel       = sel_q;
    assign bus.locked    = (state_q == LOCK);
    assign bus.err       = err_q;
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of a time-multiplexed link whose transmit end is a select-driven multiplexer cycling channel by channel. It accepts one slot per valid strobe from a serial channel stream, uses a frame marker to align channel 0, and presents each complete frame as a parallel word with a one-cycle valid pulse. Framing faults raise a sticky error and trigger resynchronisation. It sits between the link input and the per-channel consumers.

## Interface
- CHANNELS, 4: slots per frame; legal range 2..16.
- WIDTH, 1: bits per slot.
- SELW, clog2(CHANNELS): width of SEL; derived, not overridden.

- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN  in  WIDTH  slot data.
- IN_VALID  in  1  IN carries a slot this cycle.
- SYNC  in  1  qualified by IN_VALID; marks the slot as channel 0.
- ERR_CLR  in  1  clears ERR.
- OUT  out  CHANNELS*WIDTH  last complete frame; channel k at bits [k*WIDTH +: WIDTH].
- OUT_VALID  out  1  one-cycle pulse when OUT updates.
- SEL  out  SELW  channel index expected for the next valid slot.
- LOCKED  out  1  high in state LOCK.
- ERR  out  1  sticky framing-error flag.

## Operation
- Reset: state HUNT, SEL=0, OUT=0, OUT_VALID=0, LOCKED=0, ERR=0, shadow registers cleared.
- Cycles with IN_VALID=0 change nothing; SYNC is ignored.
- HUNT:
  - Valid slot with SYNC=0: dropped; no error.
  - Valid slot with SYNC=1: stored to shadow[0], SEL<=1, go to LOCK.
- LOCK, valid slot with SEL==0:
  - SYNC=1: normal frame start; store shadow[0], SEL<=1.
  - SYNC=0: missing marker. ERR<=1, slot dropped, SEL<=0, go to HUNT.
- LOCK, valid slot with 0<SEL<CHANNELS-1:
  - SYNC=0: store shadow[SEL], SEL<=SEL+1.
  - SYNC=1: early marker. ERR<=1, partial frame discarded, slot stored as channel 0, SEL<=1, stay in LOCK.
- LOCK, valid slot with SEL==CHANNELS-1:
  - SYNC=0: OUT<={IN, shadow[CHANNELS-2..0]}, OUT_VALID<=1, SEL<=0.
  - SYNC=1: handled as an early marker (rule above).
- OUT holds its value between frames. Errors never modify OUT.
- ERR: set on any framing fault. Cleared by ERR_CLR. If a fault and ERR_CLR occur in the same cycle, set wins.
- SEL wraps from CHANNELS-1 to 0 only on a completed frame. SEL never exceeds CHANNELS-1.

## Timing
- All outputs are registered; no combinational path from input to output.
- OUT and OUT_VALID update on the edge that accepts the last slot, so they are visible in the following cycle.
- Latency from the last slot to OUT_VALID is one cycle.
- OUT_VALID lasts exactly one cycle, even when back-to-back frames arrive.
- Minimum frame period is CHANNELS cycles (IN_VALID continuously high). Full throughput is required, with no bubble between frames.
- SEL, LOCKED and ERR reflect the effect of a slot one cycle after that slot is accepted.
- RESET mid-frame: partial frame discarded, OUT cleared to 0. RESET overrides all other inputs in the same cycle.

## Test plan
1. CHANNELS=4, WIDTH=1, continuous slots 1,0,1,1 with SYNC on the first slot, repeated twice -> OUT=4'b1101 (channel 0 in the LSB), OUT_VALID pulses in the cycles after slots 4 and 8, SEL sequence 1,2,3,0,1,2,3,0, ERR=0.
2. Slots with gaps: IN_VALID pattern 1,0,0,1,0,1,1 carrying a SYNC frame -> same OUT as scenario 1, OUT_VALID one cycle after the 4th valid slot, SEL frozen during gaps.
3. SYNC on the 3rd slot of a frame -> ERR=1, no OUT_VALID, OUT unchanged. Following slots 3 more -> frame completes, OUT_VALID pulses, OUT holds the realigned data.
4. Valid slot without SYNC at SEL=0 while in LOCK -> ERR=1, LOCKED=0 next cycle. Subsequent non-SYNC slots ignored. SYNC frame relocks and delivers OUT.
5. ERR_CLR asserted alone -> ERR=0 next cycle. ERR_CLR in the same cycle as an early SYNC -> ERR stays 1.
6. RESET after 2 slots of a frame, then a full SYNC frame 0,1,1,0 -> OUT=0 and SEL=0 after reset, then OUT=4'b0110 with a single OUT_VALID, ERR=0.
